data_mem_ctrl: RTL

- Data-memory controller directly downstream of the core's memory request port; consumes core load/store requests and returns load data to the core's memory-response input.
- Word-organised synchronous RAM, a fixed-latency read pipeline, and a response FIFO with valid/yumi handshake.
- Credit-based request acceptance: a read is never accepted unless its response slot is guaranteed.

---
 rtl/data_mem_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: byte-masked word RAM, latency_p-cycle load pipeline, in-order response FIFO.
// Loads are accepted only when a FIFO slot is guaranteed (credit = fifo_depth_p); stores share the same ready.
module data_mem_ctrl #(
  parameter int addr_width_p = 10,
  parameter int latency_p    = 2,
  parameter int fifo_depth_p = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_v_i,
  input  logic        req_we_i,
  input  logic [3:0]  req_mask_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        req_ready_o,
  output logic        resp_v_o,
  output logic [31:0] resp_data_o,
  input  logic        resp_yumi_i,
  output logic        err_o,
  output logic [3:0]  inflight_o
);
  localparam int Words = 1 << addr_width_p;
  localparam int PtrW  = $clog2(fifo_depth_p);
  localparam int NStg  = latency_p - 1;

  logic [31:0]             r_mem [Words];
  logic [31:0]             r_fifo [fifo_depth_p];
  logic [PtrW-1:0]         r_wr_ptr;
  logic [PtrW-1:0]         r_rd_ptr;
  logic [3:0]              r_cnt;
  logic                    r_err;

  logic                    w_acc;
  logic                    w_st_acc;
  logic                    w_ld_acc;
  logic                    w_oor;
  logic [addr_width_p-1:0] w_idx;
  logic [31:0]             w_rd_dat;
  logic                    w_push_v;
  logic [31:0]             w_push_dat;
  logic [3:0]              w_pipe_cnt;
  logic                    w_pop;
  logic                    w_unused_addr;

  assign w_unused_addr = ^req_addr_i[1:0];
  assign w_oor    = |req_addr_i[31:addr_width_p+2];
  assign w_idx    = req_addr_i[addr_width_p+1:2];
  assign w_acc    = req_v_i & req_ready_o;
  assign w_st_acc = w_acc & req_we_i;
  assign w_ld_acc = w_acc & ~req_we_i;
  assign w_rd_dat = w_oor ? 32'h0 : r_mem[w_idx];

  // Memory contents survive reset; out-of-range stores are dropped.
  always_ff @(posedge clk) begin
    if (w_st_acc && !w_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (req_mask_i[b]) r_mem[w_idx][8*b +: 8] <= req_wdata_i[8*b +: 8];
      end
    end
  end

  if (NStg == 0) begin : g_direct
    assign w_push_v   = w_ld_acc;
    assign w_push_dat = w_rd_dat;
    assign w_pipe_cnt = 4'd0;
  end else begin : g_pipe
    logic [NStg-1:0] r_stg_v;
    logic [31:0]     r_stg_dat [NStg];

    // Stage 0 is the synchronous RAM read; later stages only delay it.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_stg_v <= '0;
        for (int i = 0; i < NStg; i++) r_stg_dat[i] <= 32'h0;
      end else begin
        r_stg_v[0]   <= w_ld_acc;
        r_stg_dat[0] <= w_rd_dat;
        for (int i = 1; i < NStg; i++) begin
          r_stg_v[i]   <= r_stg_v[i-1];
          r_stg_dat[i] <= r_stg_dat[i-1];
        end
      end
    end

    always_comb begin
      w_pipe_cnt = 4'd0;
      for (int i = 0; i < NStg; i++) w_pipe_cnt = w_pipe_cnt + 4'(r_stg_v[i]);
    end

    assign w_push_v   = r_stg_v[NStg-1];
    assign w_push_dat = r_stg_dat[NStg-1];
  end

  function automatic logic [PtrW-1:0] f_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(fifo_depth_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_pop = resp_yumi_i & (r_cnt != 4'd0);

  always_ff @(posedge clk) begin
    if (w_push_v) r_fifo[r_wr_ptr] <= w_push_dat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= 4'd0;
    end else begin
      if (w_push_v) r_wr_ptr <= f_inc(r_wr_ptr);
      if (w_pop)    r_rd_ptr <= f_inc(r_rd_ptr);
      case ({w_push_v, w_pop})
        2'b10:   r_cnt <= r_cnt + 4'd1;
        2'b01:   r_cnt <= r_cnt - 4'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             r_err <= 1'b0;
    else if (w_acc && w_oor) r_err <= 1'b1;
  end

  // Credit counts loads still in the pipeline, so the FIFO can never overflow.
  assign inflight_o  = r_cnt + w_pipe_cnt;
  assign req_ready_o = inflight_o < 4'(fifo_depth_p);
  assign resp_v_o    = r_cnt != 4'd0;
  assign resp_data_o = resp_v_o ? r_fifo[r_rd_ptr] : 32'h0;
  assign err_o       = r_err;
endmodule
